// File: rtl/vga_plot_sink.sv
// vga_plot_sink: receiving end of the processor pixel-plot interface.
//
// Stores plots into a 160x120, 3-bit-per-pixel frame buffer and continuously scans
// it out as a 640x480 VGA raster (pixel rate clk/2), each stored pixel replicated 4x4.
// After reset the whole buffer is swept to CLEAR_COLOR before plots are accepted.
//
// Ports:
//   clk          in   system clock (50 MHz)
//   reset        in   synchronous, active-high
//   x, y         in   plot column / row
//   color_draw   in   plot colour {r,g,b}
//   plot         in   write strobe, sampled every clk
//   vga_r/g/b    out  pixel colour, 0 when blanked
//   vga_hs       out  horizontal sync, active-low
//   vga_vs       out  vertical sync, active-low
//   vga_blank_n  out  high during active video
//   busy         out  high while the clear sweep runs
//   drop_count   out  saturating count of out-of-range plots
module vga_plot_sink #(
  parameter int unsigned FB_W        = 160,
  parameter int unsigned FB_H        = 120,
  parameter logic [2:0]  CLEAR_COLOR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic [2:0] color_draw,
  input  logic       plot,
  output logic       vga_r,
  output logic       vga_g,
  output logic       vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       busy,
  output logic [7:0] drop_count
);

  localparam int unsigned FbWords  = FB_W * FB_H;
  localparam logic [14:0] LastAddr = 15'(FbWords - 1);

  localparam logic [0:0] StClear = 1'b0;
  localparam logic [0:0] StRun   = 1'b1;

  // Raster geometry in pixel periods; sync ranges are inclusive.
  localparam logic [9:0] HLast      = 10'd799;
  localparam logic [9:0] HActive    = 10'd640;
  localparam logic [9:0] HSyncFirst = 10'd656;
  localparam logic [9:0] HSyncLast  = 10'd751;
  localparam logic [9:0] VLast      = 10'd524;
  localparam logic [9:0] VActive    = 10'd480;
  localparam logic [9:0] VSyncFirst = 10'd490;
  localparam logic [9:0] VSyncLast  = 10'd491;

  logic [0:0]  state_q, state_d;
  logic [14:0] clr_addr_q, clr_addr_d;
  logic [7:0]  drop_q, drop_d;

  logic        pix_en_q, pix_en_d;
  logic [9:0]  hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;

  // Stage 1: read address and decoded raster flags; stage 2: RAM data and aligned flags.
  logic [14:0] rd_addr_q, rd_addr_d;
  logic        act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic        act2_q, act2_d, hs2_q, hs2_d, vs2_q, vs2_d;

  logic [2:0]  fb_q [FbWords];
  logic [2:0]  rd_data_q;

  logic        we;
  logic [14:0] waddr;
  logic [2:0]  wdata;
  logic        in_range;
  logic [14:0] plot_addr;
  logic        active;

  assign in_range  = ({24'd0, x} < FB_W) && ({24'd0, y} < FB_H);
  assign plot_addr = 15'(y) * 15'(FB_W) + 15'(x);

  // Control FSM, write port and drop counter.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    drop_d     = drop_q;
    we         = 1'b0;
    waddr      = '0;
    wdata      = '0;
    case (state_q)
      StClear: begin
        we    = 1'b1;
        waddr = clr_addr_q;
        wdata = CLEAR_COLOR;
        if (clr_addr_q == LastAddr) begin
          state_d = StRun;
        end else begin
          clr_addr_d = clr_addr_q + 15'd1;
        end
      end
      default: begin
        if (plot) begin
          if (in_range) begin
            we    = 1'b1;
            waddr = plot_addr;
            wdata = color_draw;
          end else if (drop_q != 8'hff) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
    endcase
    // No RAM write may slip through on a reset clk.
    if (reset) begin
      we = 1'b0;
    end
  end

  // Scan counters and raster decode.
  always_comb begin
    pix_en_d = ~pix_en_q;
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    if (pix_en_q) begin
      if (hcnt_q == HLast) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end

    active    = (hcnt_q < HActive) && (vcnt_q < VActive);
    // Outside the active region the computed address would run past the buffer.
    rd_addr_d = active ? 15'(vcnt_q >> 2) * 15'(FB_W) + 15'(hcnt_q >> 2) : '0;
    act1_d    = active;
    hs1_d     = !((hcnt_q >= HSyncFirst) && (hcnt_q <= HSyncLast));
    vs1_d     = !((vcnt_q >= VSyncFirst) && (vcnt_q <= VSyncLast));
    act2_d    = act1_q;
    hs2_d     = hs1_q;
    vs2_d     = vs1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StClear;
      clr_addr_q <= '0;
      drop_q     <= '0;
      pix_en_q   <= 1'b0;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      rd_addr_q  <= '0;
      act1_q     <= 1'b0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      act2_q     <= 1'b0;
      hs2_q      <= 1'b1;
      vs2_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      drop_q     <= drop_d;
      pix_en_q   <= pix_en_d;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      rd_addr_q  <= rd_addr_d;
      act1_q     <= act1_d;
      hs1_q      <= hs1_d;
      vs1_q      <= vs1_d;
      act2_q     <= act2_d;
      hs2_q      <= hs2_d;
      vs2_q      <= vs2_d;
    end
  end

  // Simple dual-port RAM; a same-address read returns the pre-write data.
  always_ff @(posedge clk) begin
    if (we) begin
      fb_q[waddr] <= wdata;
    end
    rd_data_q <= fb_q[rd_addr_q];
  end

  // RAM data is not reset; act2_q gates it to black during and after reset.
  assign vga_r       = act2_q & rd_data_q[2];
  assign vga_g       = act2_q & rd_data_q[1];
  assign vga_b       = act2_q & rd_data_q[0];
  assign vga_hs      = hs2_q;
  assign vga_vs      = vs2_q;
  assign vga_blank_n = act2_q;
  assign busy        = (state_q == StClear);
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_vga_plot_sink.sv
module tb_vga_plot_sink;

  localparam int FbWords = 19200;
  localparam int PxCheck = 2 + 2 * (20 * 800 + 41);  // raster line 20, hcnt 41 -> fb (10,5)

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] x = '0;
  logic [7:0] y = '0;
  logic [2:0] color_draw = '0;
  logic       plot = 1'b0;
  logic       vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, busy;
  logic [7:0] drop_count;

  always #10 clk = ~clk;

  vga_plot_sink dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .color_draw (color_draw),
    .plot       (plot),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .vga_blank_n(vga_blank_n),
    .busy       (busy),
    .drop_count (drop_count)
  );

  int unsigned n_checks = 0;
  int unsigned n_fails = 0;

  // Reference model: k = clk edges since the last reset edge; mem_m = -1 means unknown.
  int k = 0;
  int phase = 0;
  int mem_m[FbWords];
  int drop_m = 0;
  int hs_low_win = 0;
  int blank_win = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s at k=%0d phase=%0d: got %0d, expected %0d", tag, k, phase, got, exp);
    end
  endtask

  // Output at edge k shows pixel period (k-2)/2 of the continuous raster.
  task automatic check_outputs();
    int p, h, v, w;
    int e_hs, e_vs, e_bl, e_rgb;
    bit known;
    e_hs = 1; e_vs = 1; e_bl = 0; e_rgb = 0; known = 1'b1;
    if (k >= 2) begin
      p    = (k - 2) / 2;
      h    = p % 800;
      v    = (p / 800) % 525;
      e_bl = (h < 640 && v < 480) ? 1 : 0;
      e_hs = (h >= 656 && h < 752) ? 0 : 1;
      e_vs = (v == 490 || v == 491) ? 0 : 1;
      if (e_bl == 1) begin
        w = mem_m[(v / 4) * 160 + h / 4];
        if (w < 0) known = 1'b0;
        else e_rgb = w;
      end
    end
    check_eq("hs", vga_hs, e_hs);
    check_eq("vs", vga_vs, e_vs);
    check_eq("blank_n", vga_blank_n, e_bl);
    if (known) check_eq("rgb", {vga_r, vga_g, vga_b}, e_rgb);
    check_eq("busy", busy, (k < FbWords) ? 1 : 0);
    check_eq("drop", drop_count, drop_m);
  endtask

  task automatic tick();
    bit rs, pl;
    int xi, yi, ci, waddr, wval;
    rs = reset; pl = plot; xi = x; yi = y; ci = color_draw;
    waddr = -1; wval = 0;
    @(posedge clk);
    #1;
    if (rs) begin
      k = 0;
      drop_m = 0;
    end else begin
      k++;
      if (k <= FbWords) begin
        waddr = k - 1;
        wval  = 0;
      end else if (pl) begin
        if (xi < 160 && yi < 120) begin
          waddr = yi * 160 + xi;
          wval  = ci;
        end else if (drop_m < 255) begin
          drop_m++;
        end
      end
    end
    check_outputs();
    if (!rs && phase == 1 && k >= 1602 && k < 1602 + 16000) begin
      if (!vga_hs) hs_low_win++;
      if (vga_blank_n) blank_win++;
    end
    if (waddr >= 0) mem_m[waddr] = wval;
  endtask

  task automatic rand_in_range();
    plot       = ($urandom_range(3) == 0);
    x          = 8'($urandom_range(159));
    y          = 8'($urandom_range(29));
    if (y == 8'd5) y = 8'd6;
    color_draw = 3'($urandom);
  endtask

  task automatic rand_any();
    plot       = $urandom_range(1) == 1;
    x          = 8'($urandom);
    y          = 8'($urandom);
    color_draw = 3'($urandom);
  endtask

  task automatic count_uncleared(output int bad);
    bad = 0;
    for (int i = 0; i < FbWords; i++) begin
      if (dut.fb_q[i] !== 3'b000) bad++;
    end
  endtask

  initial begin
    int bad;
    for (int i = 0; i < FbWords; i++) mem_m[i] = -1;

    // Reset pulse, then the clear sweep with plots that must be ignored.
    phase = 1;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    while (k < FbWords) begin
      rand_any();
      if (k == 100) begin
        plot = 1'b1; x = 8'd0; y = 8'd0; color_draw = 3'b111;
      end
      tick();
    end
    plot = 1'b0;
    count_uncleared(bad);
    check_eq("clear_words", bad, 0);
    check_eq("clear_plot_ignored", dut.fb_q[0], 0);

    // Directed plots: single pixel, back-to-back row, boundary accept/reject.
    plot = 1'b1; x = 8'd10; y = 8'd5; color_draw = 3'b101;
    tick();
    for (int i = 0; i < 4; i++) begin
      x = 8'(20 + i); y = 8'd6; color_draw = 3'(i + 1);
      tick();
    end
    x = 8'd159; y = 8'd119; color_draw = 3'b110;
    tick();
    x = 8'd160; y = 8'd0;   tick();
    x = 8'd0;   y = 8'd120; tick();
    x = 8'd255; y = 8'd255; tick();
    plot = 1'b0;
    tick();
    check_eq("drop_after_3", drop_count, 3);
    check_eq("corner_written", dut.fb_q[19199], 3'b110);
    for (int i = 0; i < 4; i++) begin
      check_eq("b2b_written", dut.fb_q[6 * 160 + 20 + i], i + 1);
    end

    // Random traffic while the raster covers lines 0..24.
    while (k < 40000) begin
      rand_in_range();
      tick();
      if (k == PxCheck) begin
        check_eq("px_10_5_rgb", {vga_r, vga_g, vga_b}, 3'b101);
        check_eq("px_10_5_blank_n", vga_blank_n, 1);
      end
    end

    // Drop counter saturation.
    for (int i = 0; i < 300; i++) begin
      plot = 1'b1;
      x    = 8'($urandom_range(255, 160));
      y    = 8'($urandom);
      tick();
    end
    plot = 1'b0;
    tick();
    check_eq("drop_saturated", drop_count, 255);

    // Mid-frame reset: counters restart and the buffer is swept again.
    phase = 2;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    while (k < 38500) begin
      if (k < FbWords) rand_any();
      else rand_in_range();
      tick();
      if (k == FbWords) begin
        count_uncleared(bad);
        check_eq("reclear_words", bad, 0);
      end
      if (k == PxCheck) check_eq("px_10_5_recleared", {vga_r, vga_g, vga_b}, 0);
    end

    check_eq("hs_low_10_lines", hs_low_win, 10 * 192);
    check_eq("blank_n_10_lines", blank_win, 10 * 1280);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
